ineq_flag_tally: RTL

Downstream consumer of the 3-bit `Inequality` output vector. It accepts one flag sample per valid/ready transfer and counts, per flag bit, how many samples in a fixed-length window had that bit set. At the end of each window it presents the three counts, plus the last sample's NUM, through a valid/ready output handshake. It is the first sequential stage after the combinational inequality logic and summarises its behaviour over a sample stream.

---
 rtl/ineq_tally_pkg.sv | 25 ++
 rtl/ineq_flag_tally_if.sv | 26 ++
 rtl/ineq_bit_counter.sv | 23 ++
 rtl/ineq_flag_tally.sv | 108 ++++++++++
 4 files changed

// File: rtl/ineq_tally_pkg.sv
// Shared types and helpers for the inequality flag tally.
// Holds the FSM encoding, flag indices and the counter-width rule.
package ineq_tally_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  localparam int FLAG_BIT0 = 0;
  localparam int FLAG_BIT1 = 1;
  localparam int FLAG_BIT2 = 2;

  // Smallest width whose all-ones value can hold a full window.
  function automatic int min_cw(input int window);
    int c;
    c = 1;
    for (int i = 1; i <= 8; i++) begin
      if (((1 << c) - 1) < window) c = c + 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/ineq_flag_tally_if.sv
// Sample-in / result-out handshake bundle for ineq_flag_tally.
// master drives samples and takes results; slave is the tally.
interface ineq_flag_tally_if #(
  parameter int CW = 5
);
  logic [3:0]    num_in;
  logic [2:0]    flags_in;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] cnt2;
  logic [CW-1:0] cnt1;
  logic [CW-1:0] cnt0;
  logic [3:0]    last_num;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output num_in, flags_in, in_valid, out_ready,
    input  in_ready, cnt2, cnt1, cnt0, last_num, out_valid
  );

  modport slave (
    input  num_in, flags_in, in_valid, out_ready,
    output in_ready, cnt2, cnt1, cnt0, last_num, out_valid
  );
endinterface

// File: rtl/ineq_bit_counter.sv
// Per-flag set counter: synchronous clear, then increment.
// Reset and clear both zero it; clear wins over increment.
module ineq_bit_counter #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ineq_flag_tally.sv
// Windowed tally of the 3-bit inequality flags with a held result.
// FSM IDLE/ACCUM/HOLD; in_ready and out_valid decode the state register.
module ineq_flag_tally
  import ineq_tally_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int CW     = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  ineq_flag_tally_if.slave bus
);

  if (WINDOW < 1 || WINDOW > 255) begin : g_bad_window
    $error("ineq_flag_tally: WINDOW out of range 1..255");
  end

  if (CW < min_cw(WINDOW)) begin : g_bad_cw
    $error("ineq_flag_tally: CW too narrow for WINDOW");
  end

  localparam logic [7:0] LAST_IDX = 8'(WINDOW - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] n;
  logic [3:0] last_q;
  logic       acc;
  logic       win_done;
  logic       clr_cnt;

  assign bus.in_ready  = (state != HOLD);
  assign bus.out_valid = (state == HOLD);
  assign bus.last_num  = last_q;

  // A clear in the same cycle swallows the offered sample.
  assign acc      = bus.in_valid && (state != HOLD) && !clear;
  assign win_done = acc && (n == LAST_IDX);
  assign clr_cnt  = ((state != HOLD) && clear)
                 || ((state == HOLD) && bus.out_ready);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, ACCUM: begin
        if (clear)         state_next = IDLE;
        else if (win_done) state_next = HOLD;
        else if (acc)      state_next = ACCUM;
      end
      HOLD: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n <= '0;
    end else if (clr_cnt) begin
      n <= '0;
    end else if (acc) begin
      n <= n + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= '0;
    end else if (win_done) begin
      last_q <= bus.num_in;
    end
  end

  ineq_bit_counter #(.CW(CW)) u_cnt0 (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .inc   (acc && bus.flags_in[FLAG_BIT0]),
    .count (bus.cnt0)
  );

  ineq_bit_counter #(.CW(CW)) u_cnt1 (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .inc   (acc && bus.flags_in[FLAG_BIT1]),
    .count (bus.cnt1)
  );

  ineq_bit_counter #(.CW(CW)) u_cnt2 (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .inc   (acc && bus.flags_in[FLAG_BIT2]),
    .count (bus.cnt2)
  );

endmodule
